mips_muldiv_ctrl: RTL and testbench

- Sequencer for the HI/LO multiply/divide resource of the MIPS pipeline.
- Accepts MULT/MULTU/DIV/DIVU launches from execute and runs an iterative shift-add multiply or restoring divide over WIDTH cycles.
- Owns the HI and LO registers and services MTHI/MTLO/MFHI/MFLO.
- Raises stall to the pipeline when an access targets HI/LO while an operation is in flight.

---
 rtl/mips_muldiv_pkg.sv | 20 ++
 rtl/mips_muldiv_step.sv | 37 +++
 rtl/mips_muldiv_ctrl.sv | 164 ++++++++++++++++
 tb/tb_mips_muldiv_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_muldiv_pkg.sv
// rtl/mips_muldiv_pkg.sv - shared types and constants for the HI/LO multiply/divide sequencer
package mips_muldiv_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'd0,
        MD_MULTU = 2'd1,
        MD_DIV   = 2'd2,
        MD_DIVU  = 2'd3
    } muldiv_op_t;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_FIX  = 2'd2
    } muldiv_state_t;

    // Replicated across LO when a divide sees a zero divisor.
    localparam logic MD_DZ_LO_FILL = 1'b1;

endpackage

// File: rtl/mips_muldiv_step.sv
// rtl/mips_muldiv_step.sv - one combinational iteration of shift-add multiply or restoring divide
module mips_muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc_in,
    input  logic [WIDTH-1:0]   operand,
    input  logic               is_div,
    output logic [2*WIDTH-1:0] acc_out,
    output logic               q_bit
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] rem_next;

    always_comb begin
        sum      = {1'b0, acc_in[2*WIDTH-1:WIDTH]};
        diff     = acc_in[2*WIDTH-1:WIDTH-1] - {1'b0, operand};
        q_bit    = 1'b0;
        rem_next = acc_in[2*WIDTH-2:WIDTH-1];
        acc_out  = acc_in;
        if (is_div) begin
            // Top bit of the (W+1)-bit difference set means the trial went negative.
            q_bit = ~diff[WIDTH];
            if (q_bit) begin
                rem_next = diff[WIDTH-1:0];
            end
            acc_out = {rem_next, acc_in[WIDTH-2:0], q_bit};
        end else begin
            if (acc_in[0]) begin
                sum = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + {1'b0, operand};
            end
            acc_out = {sum, acc_in[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mips_muldiv_ctrl.sv
// rtl/mips_muldiv_ctrl.sv - HI/LO sequencer, iterative MULT/DIV; MULDIV_EARLY_OUT_EN enables multiply early-out
module mips_muldiv_ctrl
    import mips_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_hi,
    input  logic             rd_lo,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             busy,
    output logic             stall,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    muldiv_state_t    state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic             is_div_q, is_div_d;
    logic             neg_a_q, neg_a_d;
    logic             neg_b_q, neg_b_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    muldiv_op_t       op_e;
    logic             signed_op;
    logic             div_op;
    logic [WIDTH-1:0] rs_abs;
    logic [WIDTH-1:0] rt_abs;
    logic [2*WIDTH-1:0] step_acc;
    logic             step_q;
    logic [2*WIDTH-1:0] prod_fix;
`ifdef MULDIV_EARLY_OUT_EN
    logic [WIDTH-1:0] rem_mask;
    logic [CW-1:0]    rem_cnt;
`endif

    mips_muldiv_step #(.WIDTH(WIDTH)) u_step (
        .acc_in  (acc_q),
        .operand (opnd_q),
        .is_div  (is_div_q),
        .acc_out (step_acc),
        .q_bit   (step_q)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        op_e      = muldiv_op_t'(op);
        signed_op = (op_e == MD_MULT) || (op_e == MD_DIV);
        div_op    = (op_e == MD_DIV) || (op_e == MD_DIVU);
        rs_abs    = (signed_op && rs_data[WIDTH-1]) ? -rs_data : rs_data;
        rt_abs    = (signed_op && rt_data[WIDTH-1]) ? -rt_data : rt_data;
        prod_fix  = neg_a_q ? -acc_q : acc_q;
`ifdef MULDIV_EARLY_OUT_EN
        rem_mask  = {WIDTH{1'b1}} >> cnt_q;
        rem_cnt   = CW'(WIDTH) - cnt_q;
`endif

        case (state_q)
            MD_IDLE: begin
                if (start) begin
                    is_div_d = div_op;
                    cnt_d    = '0;
                    if (div_op && (rt_data == '0)) begin
                        acc_d   = {rs_data, {WIDTH{MD_DZ_LO_FILL}}};
                        neg_a_d = 1'b0;
                        neg_b_d = 1'b0;
                        state_d = MD_FIX;
                    end else begin
                        // Multiply: low half holds the multiplier being consumed.
                        // Divide: low half holds the dividend shifting out into the remainder.
                        acc_d   = {{WIDTH{1'b0}}, div_op ? rs_abs : rt_abs};
                        opnd_d  = div_op ? rt_abs : rs_abs;
                        neg_a_d = signed_op && (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
                        neg_b_d = signed_op && div_op && rs_data[WIDTH-1];
                        state_d = MD_CALC;
                    end
                end else begin
                    if (hi_we) hi_d = wr_data;
                    if (lo_we) lo_d = wr_data;
                end
            end
            MD_CALC: begin
                acc_d = is_div_q ? {step_acc[2*WIDTH-1:1], step_q} : step_acc;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = MD_FIX;
                end
`ifdef MULDIV_EARLY_OUT_EN
                if (!is_div_q && ((acc_q[WIDTH-1:0] & rem_mask) == '0)) begin
                    acc_d   = acc_q >> rem_cnt;
                    state_d = MD_FIX;
                end
`endif
            end
            MD_FIX: begin
                if (is_div_q) begin
                    lo_d = neg_a_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                    hi_d = neg_b_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                end else begin
                    lo_d = prod_fix[WIDTH-1:0];
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                end
                cnt_d   = '0;
                state_d = MD_IDLE;
            end
            default: begin
                state_d = MD_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= MD_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign hi_out = hi_q;
    assign lo_out = lo_q;
    assign busy   = (state_q != MD_IDLE);
    assign stall  = busy & (start | hi_we | lo_we | rd_hi | rd_lo);
    assign done   = (state_q == MD_FIX);

endmodule

// File: tb/tb_mips_muldiv_ctrl.sv
// tb/tb_mips_muldiv_ctrl.sv - scoreboard bench for mips_muldiv_ctrl with a behavioural arithmetic model
module tb_mips_muldiv_ctrl;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] rs_data, rt_data, wr_data;
    logic         hi_we, lo_we, rd_hi, rd_lo;
    logic [W-1:0] hi_out, lo_out;
    logic         busy, stall, done;

    mips_muldiv_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .rs_data(rs_data), .rt_data(rt_data),
        .hi_we(hi_we), .lo_we(lo_we), .wr_data(wr_data),
        .rd_hi(rd_hi), .rd_lo(rd_lo),
        .hi_out(hi_out), .lo_out(lo_out),
        .busy(busy), .stall(stall), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           lat;
        int           done_cyc;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input int c0);
        exp_t         e;
        longint       sa, sb;
        logic [63:0]  p, ua, ub;
        logic [W-1:0] m;
        int           hb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        e.lat = W + 1;
        p = 64'd0;
        case (o)
            2'd0: p = sa * sb;
            2'd1: p = ua * ub;
            2'd2: begin
                if (b == 0) p = {a, 32'hFFFF_FFFF};
                else begin
                    p[31:0]  = 32'(sa / sb);
                    p[63:32] = 32'(sa % sb);
                end
            end
            default: begin
                if (b == 0) p = {a, 32'hFFFF_FFFF};
                else begin
                    p[31:0]  = a / b;
                    p[63:32] = a % b;
                end
            end
        endcase
        if (o[1] && b == 0) e.lat = 1;
`ifdef MULDIV_EARLY_OUT_EN
        if (!o[1]) begin
            m  = (o == 2'd0 && b[W-1]) ? -b : b;
            hb = -1;
            for (int i = 0; i < W; i++) if (m[i]) hb = i;
            if (hb < 0) e.lat = 2;
            else e.lat = (hb + 3 < W + 1) ? hb + 3 : W + 1;
        end
`else
        m  = '0;
        hb = 0;
        if (m != '0) hb = 1;
`endif
        e.hi = p[63:32];
        e.lo = p[31:0];
        e.done_cyc = c0 + e.lat;
        return e;
    endfunction

    // Monitor: each done pulse consumes one expectation; HI/LO are checked the cycle after.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done) begin
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: got done=1 at cycle %0d expected no result pending", cyc);
                end else begin
                    e = sbq.pop_front();
                    chk("done_cycle", 64'(cyc), 64'(e.done_cyc));
                    @(negedge clk);
                    chk("hi_result", 64'(hi_out), 64'(e.hi));
                    chk("lo_result", 64'(lo_out), 64'(e.lo));
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) assert (!(start && !busy && (hi_we || lo_we)))
            else $error("start together with MTHI/MTLO in idle");
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic launch(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b, output exp_t e);
        @(posedge clk); #1;
        start = 1'b1; op = o; rs_data = a; rt_data = b;
        e = model(o, a, b, cyc);
        sbq.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(output int nbusy);
        bit fin;
        fin = 0;
        nbusy = 0;
        for (int i = 0; i < 200 && !fin; i++) begin
            @(negedge clk);
            if (busy) nbusy++;
            else fin = 1;
        end
        if (!fin) begin
            n_cmp++;
            n_bad++;
            $display("FAIL busy_timeout: got busy after 200 cycles expected idle");
        end
    endtask

    initial begin
        exp_t         e, e2;
        int           nb, nst, nhi;
        logic [W-1:0] hi_prev;
        logic [1:0]   ro;
        logic [W-1:0] ra, rb;

        rst = 1'b1; start = 1'b0; op = 2'd0; rs_data = '0; rt_data = '0;
        hi_we = 1'b0; lo_we = 1'b0; wr_data = '0; rd_hi = 1'b0; rd_lo = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_hi", 64'(hi_out), 64'd0);
        chk("reset_lo", 64'(lo_out), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_stall", 64'(stall), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        @(posedge clk); #1 rst = 1'b0;

        launch(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, e);
        wait_idle(nb);
        chk("multu_busy_cycles", 64'(nb), 64'(W + 1));
        chk("multu_model_hi", 64'(e.hi), 64'hFFFF_FFFE);

        launch(2'd0, 32'hFFFF_FFF9, 32'd3, e); wait_idle(nb);
        launch(2'd2, 32'hFFFF_FFF9, 32'd2, e); wait_idle(nb);
        launch(2'd3, 32'd100, 32'd0, e); wait_idle(nb);
        chk("div0_busy_cycles", 64'(nb), 64'd1);
        launch(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, e); wait_idle(nb);
        launch(2'd0, 32'h8000_0000, 32'h8000_0000, e); wait_idle(nb);
        launch(2'd2, 32'h8000_0001, 32'd0, e); wait_idle(nb);
        launch(2'd1, 32'h1234_5678, 32'd1, e); wait_idle(nb);
        chk("multu_rt1_busy", 64'(nb), 64'(e.lat));

        // MFLO held from cycle 5 of a MULT until the cycle after done.
        launch(2'd0, 32'hFFFF_FFFB, 32'h4000_0003, e);
        repeat (4) @(posedge clk);
        #1 rd_lo = 1'b1;
        nst = 0;
        nb  = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) break;
            nb++;
            if (stall) nst++;
        end
        chk("mflo_stall_cycles", 64'(nst), 64'(e.lat - 4));
        chk("mflo_stall_released", 64'(stall), 64'd0);
        chk("mflo_lo_value", 64'(lo_out), 64'(e.lo));
        @(posedge clk); #1 rd_lo = 1'b0;

        // MTHI held during busy must not land until busy falls.
        hi_prev = hi_out;
        launch(2'd1, 32'h0000_0F0F, 32'h8765_4321, e);
        #1 hi_we = 1'b1; wr_data = 32'h0000_1234;
        nhi = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) break;
            if (hi_out !== hi_prev) nhi++;
        end
        chk("mthi_hi_held_while_busy", 64'(nhi), 64'd0);
        @(posedge clk); #1 hi_we = 1'b0;
        @(negedge clk);
        chk("mthi_hi_written", 64'(hi_out), 64'h1234);
        chk("mthi_lo_kept", 64'(lo_out), 64'(e.lo));

        // MTHI and MTLO together in idle.
        @(posedge clk); #1 hi_we = 1'b1; lo_we = 1'b1; wr_data = 32'hCAFE_F00D;
        @(posedge clk); #1 hi_we = 1'b0; lo_we = 1'b0;
        @(negedge clk);
        chk("idle_both_hi", 64'(hi_out), 64'hCAFE_F00D);
        chk("idle_both_lo", 64'(lo_out), 64'hCAFE_F00D);

        // Reset at cycle 10 of an operation aborts it with no result.
        launch(2'd1, 32'hDEAD_BEEF, 32'h8000_0001, e);
        e2 = sbq.pop_back();
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_hi", 64'(hi_out), 64'd0);
        chk("abort_lo", 64'(lo_out), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        repeat (40) @(negedge clk);
        chk("abort_stays_idle", 64'(busy), 64'd0);

        for (int n = 0; n < 40; n++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: rb = 32'($urandom_range(1, 15));
                2: rb = ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'hFFFF_FFFF;
                3: rb = $urandom >> $urandom_range(1, 30);
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            launch(ro, ra, rb, e);
            wait_idle(nb);
            chk("rand_busy_cycles", 64'(nb), 64'(e.lat));
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
